// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings and FSM states.
// Opcodes 0 and 7 are deliberately left unassigned and decode as no-ops.
package mul_div_unit_pkg;

  localparam logic [2:0] MDU_MULT  = 3'd1;
  localparam logic [2:0] MDU_MULTU = 3'd2;
  localparam logic [2:0] MDU_DIV   = 3'd3;
  localparam logic [2:0] MDU_DIVU  = 3'd4;
  localparam logic [2:0] MDU_MTHI  = 3'd5;
  localparam logic [2:0] MDU_MTLO  = 3'd6;

  localparam logic [0:0] MDU_IDLE = 1'b0;
  localparam logic [0:0] MDU_RUN  = 1'b1;

  function automatic logic is_mul_op(input logic [2:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU);
  endfunction

  function automatic logic is_div_op(input logic [2:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mul_div_unit_core.sv
// Combinational multiply/divide datapath. Works on the latched operands and
// produces the full {hi,lo} result, including divide-by-zero and overflow.
module mdu_core
  import mul_div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi_res,
  output logic [WIDTH-1:0] lo_res
);

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic                 is_signed;
  logic                 a_neg;
  logic                 b_neg;
  logic [2*WIDTH-1:0]   ext_a;
  logic [2*WIDTH-1:0]   ext_b;
  logic [2*WIDTH-1:0]   prod;
  logic [WIDTH-1:0]     mag_a;
  logic [WIDTH-1:0]     mag_b;
  logic [WIDTH-1:0]     div_b;
  logic [WIDTH-1:0]     q_mag;
  logic [WIDTH-1:0]     r_mag;
  logic [WIDTH-1:0]     quo;
  logic [WIDTH-1:0]     rem;

  always_comb begin
    is_signed = (op == MDU_MULT) || (op == MDU_DIV);
    a_neg     = is_signed & a[WIDTH-1];
    b_neg     = is_signed & b[WIDTH-1];

    // Sign-extend to 2*WIDTH so one unsigned multiplier serves both flavours.
    ext_a = {{WIDTH{a_neg}}, a};
    ext_b = {{WIDTH{b_neg}}, b};
    prod  = ext_a * ext_b;

    // Divide on magnitudes, then fix signs: quotient truncates toward zero,
    // remainder follows the dividend.
    mag_a = a_neg ? (~a + 1'b1) : a;
    mag_b = b_neg ? (~b + 1'b1) : b;
    div_b = (mag_b == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : mag_b;
    q_mag = mag_a / div_b;
    r_mag = mag_a % div_b;
    quo   = (a_neg ^ b_neg) ? (~q_mag + 1'b1) : q_mag;
    rem   = a_neg ? (~r_mag + 1'b1) : r_mag;

    hi_res = '0;
    lo_res = '0;
    if (is_mul_op(op)) begin
      {hi_res, lo_res} = prod;
    end else if (is_div_op(op)) begin
      if (b == '0) begin
        hi_res = a;
        lo_res = '1;
      end else if (is_signed && (a == MIN_NEG) && (b == '1)) begin
        hi_res = '0;
        lo_res = a;
      end else begin
        hi_res = rem;
        lo_res = quo;
      end
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Owns the IDLE/RUN FSM, latency counter, operand latches and HI/LO.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);
  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);

  logic [0:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_hi;
  logic [WIDTH-1:0] res_lo;

  mdu_core #(.WIDTH(WIDTH)) u_core (
    .op     (op_q),
    .a      (a_q),
    .b      (b_q),
    .hi_res (res_hi),
    .lo_res (res_lo)
  );

  assign busy = (state == MDU_RUN);

  // start is only looked at in IDLE; while RUN it is dropped without effect.
  // The commit edge is the one where cnt has already reached zero.
  always_ff @(posedge clk) begin
    if (clr) begin
      state <= MDU_IDLE;
      cnt   <= '0;
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      case (state)
        MDU_IDLE: begin
          if (start) begin
            if (is_mul_op(op) || is_div_op(op)) begin
              op_q  <= op;
              a_q   <= a;
              b_q   <= b;
              cnt   <= is_mul_op(op) ? MUL_CNT : DIV_CNT;
              state <= MDU_RUN;
            end else if (op == MDU_MTHI) begin
              hi <= a;
            end else if (op == MDU_MTLO) begin
              lo <= a;
            end
          end
        end
        MDU_RUN: begin
          if (cnt == '0) begin
            hi    <= res_hi;
            lo    <= res_lo;
            state <= MDU_IDLE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: state <= MDU_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: default 32-bit instance plus a
// WIDTH=16 / MUL_LAT=1 / DIV_LAT=3 instance sharing clock and clear.
module tb_mul_div_unit;
  import mul_div_unit_pkg::*;

  logic        clk = 1'b0;
  logic        clr;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a, b, hi, lo;
  logic        busy;
  logic        start16;
  logic [2:0]  op16;
  logic [15:0] a16, b16, hi16, lo16;
  logic        busy16;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected architectural HI/LO, maintained from hand-computed constants.
  logic [31:0] m_hi, m_lo;
  logic [15:0] m_hi16, m_lo16;

  mul_div_unit dut (
    .clk(clk), .clr(clr), .start(start), .op(op), .a(a), .b(b),
    .hi(hi), .lo(lo), .busy(busy)
  );

  mul_div_unit #(.WIDTH(16), .MUL_LAT(1), .DIV_LAT(3)) dut16 (
    .clk(clk), .clr(clr), .start(start16), .op(op16), .a(a16), .b(b16),
    .hi(hi16), .lo(lo16), .busy(busy16)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic run32(input string tag, input logic [2:0] o, input logic [31:0] av,
                       input logic [31:0] bv, input int lat,
                       input logic [31:0] eh, input logic [31:0] el);
    start = 1'b1; op = o; a = av; b = bv;
    step();
    start = 1'b0; a = $urandom; b = $urandom;
    for (int i = 0; i < lat; i++) begin
      check({tag, " busy"}, 64'(busy), 64'(1'b1));
      check({tag, " hold hi"}, 64'(hi), 64'(m_hi));
      check({tag, " hold lo"}, 64'(lo), 64'(m_lo));
      step();
    end
    check({tag, " busy done"}, 64'(busy), 64'(1'b0));
    check({tag, " hi"}, 64'(hi), 64'(eh));
    check({tag, " lo"}, 64'(lo), 64'(el));
    m_hi = eh; m_lo = el;
  endtask

  task automatic run16(input string tag, input logic [2:0] o, input logic [15:0] av,
                       input logic [15:0] bv, input int lat,
                       input logic [15:0] eh, input logic [15:0] el);
    start16 = 1'b1; op16 = o; a16 = av; b16 = bv;
    step();
    start16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom);
    for (int i = 0; i < lat; i++) begin
      check({tag, " busy"}, 64'(busy16), 64'(1'b1));
      check({tag, " hold hi"}, 64'(hi16), 64'(m_hi16));
      check({tag, " hold lo"}, 64'(lo16), 64'(m_lo16));
      step();
    end
    check({tag, " busy done"}, 64'(busy16), 64'(1'b0));
    check({tag, " hi"}, 64'(hi16), 64'(eh));
    check({tag, " lo"}, 64'(lo16), 64'(el));
    m_hi16 = eh; m_lo16 = el;
  endtask

  initial begin
    clr = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    start16 = 1'b0; op16 = '0; a16 = '0; b16 = '0;
    step(); step();
    clr = 1'b0;
    m_hi = '0; m_lo = '0; m_hi16 = '0; m_lo16 = '0;
    check("reset hi", 64'(hi), 64'(0));
    check("reset lo", 64'(lo), 64'(0));
    check("reset busy", 64'(busy), 64'(0));
    check("reset16 hi", 64'(hi16), 64'(0));
    check("reset16 lo", 64'(lo16), 64'(0));
    check("reset16 busy", 64'(busy16), 64'(0));

    // MTHI / MTLO are single-cycle and leave the other register alone
    start = 1'b1; op = MDU_MTHI; a = 32'h0000_1234;
    step();
    start = 1'b0;
    check("mthi busy", 64'(busy), 64'(0));
    check("mthi hi", 64'(hi), 64'(32'h1234));
    check("mthi lo", 64'(lo), 64'(0));
    step();
    check("mthi busy later", 64'(busy), 64'(0));
    start = 1'b1; op = MDU_MTLO; a = 32'h0000_0055;
    step();
    start = 1'b0;
    check("mtlo busy", 64'(busy), 64'(0));
    check("mtlo hi", 64'(hi), 64'(32'h1234));
    check("mtlo lo", 64'(lo), 64'(32'h55));
    m_hi = 32'h1234; m_lo = 32'h55;

    run32("mult -2*3",   MDU_MULT,  32'hFFFF_FFFE, 32'd3,        5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run32("multu max",   MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 32'hFFFF_FFFE, 32'h0000_0001);
    run32("mult 0x10000^2", MDU_MULT, 32'h0001_0000, 32'h0001_0000, 5, 32'h0000_0001, 32'h0000_0000);
    run32("div -7/2",    MDU_DIV,   32'hFFFF_FFF9, 32'd2,        10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run32("div 7/-2",    MDU_DIV,   32'd7,         32'hFFFF_FFFE, 10, 32'h0000_0001, 32'hFFFF_FFFD);
    run32("divu 7/0",    MDU_DIVU,  32'd7,         32'd0,        10, 32'h0000_0007, 32'hFFFF_FFFF);
    run32("div ovf",     MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0000_0000, 32'h8000_0000);
    run32("divu big",    MDU_DIVU,  32'hFFFF_FFF9, 32'd2,        10, 32'h0000_0001, 32'h7FFF_FFFC);

    // Starts during busy cycles 3 and 10 (the commit cycle) must be ignored
    start = 1'b1; op = MDU_DIV; a = 32'd100; b = 32'd7;
    step();
    start = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      if (k == 3) begin
        start = 1'b1; op = MDU_MULT; a = 32'd3; b = 32'd3;
      end else if (k == 10) begin
        start = 1'b1; op = MDU_MULT; a = 32'd5; b = 32'd6;
      end else begin
        start = 1'b0;
      end
      check("ign busy", 64'(busy), 64'(1));
      check("ign hold hi", 64'(hi), 64'(m_hi));
      check("ign hold lo", 64'(lo), 64'(m_lo));
      step();
    end
    check("ign div busy done", 64'(busy), 64'(0));
    check("ign div hi", 64'(hi), 64'(32'd2));
    check("ign div lo", 64'(lo), 64'(32'd14));
    m_hi = 32'd2; m_lo = 32'd14;
    // start still held with MULT 5*6: accepted the cycle after busy falls
    step();
    start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check("follow busy", 64'(busy), 64'(1));
      step();
    end
    check("follow busy done", 64'(busy), 64'(0));
    check("follow hi", 64'(hi), 64'(0));
    check("follow lo", 64'(lo), 64'(32'd30));
    m_hi = '0; m_lo = 32'd30;

    // clr at busy cycle 4 aborts the divide with no later commit
    start = 1'b1; op = MDU_DIV; a = 32'd100; b = 32'd7;
    step();
    start = 1'b0;
    step(); step(); step();
    check("abort pre busy", 64'(busy), 64'(1));
    clr = 1'b1;
    step();
    clr = 1'b0;
    m_hi = '0; m_lo = '0; m_hi16 = '0; m_lo16 = '0;
    check("abort busy", 64'(busy), 64'(0));
    check("abort hi", 64'(hi), 64'(0));
    check("abort lo", 64'(lo), 64'(0));
    repeat (12) step();
    check("abort later busy", 64'(busy), 64'(0));
    check("abort later hi", 64'(hi), 64'(0));
    check("abort later lo", 64'(lo), 64'(0));

    run16("m16 -2*3",   MDU_MULT,  16'hFFFE, 16'h0003, 1, 16'hFFFF, 16'hFFFA);
    run16("m16u max",   MDU_MULTU, 16'hFFFF, 16'hFFFF, 1, 16'hFFFE, 16'h0001);
    run16("d16 -7/2",   MDU_DIV,   16'hFFF9, 16'h0002, 3, 16'hFFFF, 16'hFFFD);
    run16("d16u",       MDU_DIVU,  16'hFFFF, 16'h0010, 3, 16'h000F, 16'h0FFF);
    run16("d16 ovf",    MDU_DIV,   16'h8000, 16'hFFFF, 3, 16'h0000, 16'h8000);
    run16("d16u by0",   MDU_DIVU,  16'h0123, 16'h0000, 3, 16'h0123, 16'hFFFF);

    start16 = 1'b1; op16 = MDU_DIVU; a16 = 16'd50; b16 = 16'd3;
    step();
    start16 = 1'b0;
    step();
    check("abort16 pre busy", 64'(busy16), 64'(1));
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("abort16 busy", 64'(busy16), 64'(0));
    check("abort16 hi", 64'(hi16), 64'(0));
    check("abort16 lo", 64'(lo16), 64'(0));
    repeat (6) step();
    check("abort16 later hi", 64'(hi16), 64'(0));
    check("abort16 later lo", 64'(lo16), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers, sitting in the execute stage beside the ALU.
- Adds MULT/MULTU/DIV/DIVU/MTHI/MTLO support to the five-stage pipeline.
- Exposes a busy flag so the hazard unit can stall MFHI/MFLO and further MDU ops.
- Width and per-operation latency are parameters; the single-cycle ALU path is untouched.

Parameters:
- WIDTH, 32, operand and HI/LO width in bits.
- MUL_LAT, 5, cycles from accepted MULT/MULTU to HI/LO update. Must be >= 1.
- DIV_LAT, 10, cycles from accepted DIV/DIVU to HI/LO update. Must be >= 1.

Ports:
- clk  in  1  rising-edge clock.
- clr  in  1  synchronous active-high reset.
- start  in  1  request valid this cycle; driven by E-stage decode.
- op  in  3  operation code: MULT, MULTU, DIV, DIVU, MTHI, MTLO (encodings in package; other values are no-op).
- a  in  WIDTH  forwarded rs value (E-stage forwarding mux output).
- b  in  WIDTH  forwarded rt value.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.
- busy  out  1  long-latency operation in flight.

Behaviour:
- Reset: on a clk edge with clr=1, hi=0, lo=0, busy=0, counter=0, and any in-flight operation is aborted with no HI/LO write. clr has priority over all other inputs.
- States:
  - IDLE: busy=0.
  - RUN: busy=1, down-counter cnt active.
- Accept rule: start is sampled only in IDLE. start while busy=1 is ignored entirely, with no latch and no HI/LO change. The hazard unit guarantees this does not happen; the bench checks that it is ignored.
- MUL ops, accepted at edge T:
  - latch a, b, op; cnt=MUL_LAT-1; busy=1.
  - At edge T+MUL_LAT: {hi,lo} = 2*WIDTH-bit product (signed for MULT, unsigned for MULTU); busy=0.
  - busy is therefore high for exactly MUL_LAT cycles.
- DIV ops: same sequence with DIV_LAT.
  - lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - Unsigned for DIVU.
- Divide-by-zero (b=0): lo = all ones, hi = a. Latency is unchanged.
- Signed overflow (a = most negative value, b = -1): lo = a, hi = 0.
- MTHI/MTLO in IDLE: single-cycle. At the accepting edge hi<=a (MTHI) or lo<=a (MTLO); busy stays 0 and the other register is unchanged.
- Output timing:
  - hi and lo only change at a commit edge, an MTHI/MTLO edge, or reset.
  - During RUN they hold their pre-start values.
- Result computation:
  - Uses the latched operands only; a and b may change freely after acceptance.
  - Implementation may be a combinational result delayed by the counter, or iterative, provided commit timing is exact.
- Completion and new start:
  - In the commit cycle (cnt=0) busy is still 1, so a start in that cycle is ignored.
  - A new op may be accepted on the cycle after busy falls.
- Stall contract: the hazard unit stalls D whenever (start|busy) and the D instruction is MFHI, MFLO or any MDU op. This logic is not in this block.
- Counter width: $clog2(max(MUL_LAT,DIV_LAT)+1).

Decomposition:
- Shared package/header (alongside head.v) holds:
  - mdu op encodings: MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU, MDU_MTHI, MDU_MTLO.
  - state encoding: MDU_IDLE, MDU_RUN.
- Sub-module mdu_core: pure combinational, takes latched op/a/b and returns the {hi,lo} result including the divide-by-zero and overflow rules. The top level owns the FSM, counter, operand latches and HI/LO registers.

Test Plan:
- MULT, a=0xFFFFFFFE (-2), b=3, default params -> busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA; hi/lo unchanged during busy.
- MULTU, a=0xFFFFFFFF, b=0xFFFFFFFF -> after 5 cycles hi=0xFFFFFFFE, lo=0x00000001.
- DIV, a=-7 (0xFFFFFFF9), b=2 -> after 10 cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7/0 -> lo=0xFFFFFFFF, hi=7. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTHI a=0x1234 in IDLE -> hi=0x1234 next edge, busy never asserts, lo unchanged. Then a MULT start with the operands changed the following cycle -> result uses the latched values.
- DIV started, second MULT start at cycles 3 and 10 of busy -> both ignored, DIV result committed; MULT issued the cycle after busy falls -> accepted.
- DIV started, clr pulsed at busy cycle 4 -> next edge hi=lo=0, busy=0, no later commit. Repeat with WIDTH=16, MUL_LAT=1, DIV_LAT=3 -> busy 1 and 3 cycles, 16-bit results correct.
